// File: rtl/pc_gen_ras.sv
// Program-counter generator with a circular return-address stack; next PC is visible one cycle after PC_SRC is sampled.
// STALL freezes PC, MISALIGN and the whole RAS; RST overrides everything.
module pc_gen_ras #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic [2:0]      PC_SRC,
  input  logic [XLEN-1:0] JALR_TGT,
  input  logic [XLEN-1:0] BRANCH_TGT,
  input  logic [XLEN-1:0] JAL_TGT,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  input  logic            RAS_PUSH,
  input  logic            RAS_POP,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS,
  output logic [XLEN-1:0] RAS_TOP,
  output logic            RAS_EMPTY,
  output logic            RAS_FULL,
  output logic            MISALIGN
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            misalign_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [XLEN-1:0] cand;
  logic            do_push;
  logic            do_pop;
  logic            replace_top;
  logic [PW-1:0]   wr_idx;

  assign PC        = pc_q;
  assign PC_PLUS   = pc_q + XLEN'(INC);
  assign MISALIGN  = misalign_q;
  assign RAS_EMPTY = (cnt_q == '0);
  assign RAS_FULL  = (cnt_q == CNT_MAX);
  assign RAS_TOP   = RAS_EMPTY ? '0 : ras_mem[ptr_q];

  always_comb begin
    cand = PC_PLUS;
    case (PC_SRC)
      3'd1:    cand = JALR_TGT;
      3'd2:    cand = BRANCH_TGT;
      3'd3:    cand = JAL_TGT;
      3'd4:    cand = MTVEC;
      3'd5:    cand = MEPC;
      3'd6:    cand = RAS_EMPTY ? PC_PLUS : RAS_TOP;
      default: cand = PC_PLUS;
    endcase
  end

  // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
  assign do_push     = !RST && !STALL && RAS_PUSH;
  assign do_pop      = !RST && !STALL && RAS_POP && !RAS_EMPTY;
  assign replace_top = do_push && do_pop;
  assign wr_idx      = replace_top ? ptr_q : ptr_q + PW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else if (!STALL) begin
      pc_q       <= {cand[XLEN-1:2], 2'b00};
      misalign_q <= |cand[1:0];
      if (do_push && !replace_top) begin
        ptr_q <= ptr_q + PW'(1);
        if (!RAS_FULL) cnt_q <= cnt_q + CW'(1);
      end else if (do_pop && !replace_top) begin
        ptr_q <= ptr_q - PW'(1);
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) ras_mem[wr_idx] <= PC_PLUS;
  end

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: a queue-based reference model checked every cycle plus literal checkpoints.
module tb_pc_gen_ras;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic [2:0]  PC_SRC = 3'd0;
  logic [31:0] JALR_TGT = '0, BRANCH_TGT = '0, JAL_TGT = '0, MTVEC = '0, MEPC = '0;
  logic        RAS_PUSH = 1'b0, RAS_POP = 1'b0;
  logic [31:0] PC, PC_PLUS, RAS_TOP;
  logic        RAS_EMPTY, RAS_FULL, MISALIGN;

  pc_gen_ras dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .PC_SRC(PC_SRC),
    .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT),
    .MTVEC(MTVEC), .MEPC(MEPC), .RAS_PUSH(RAS_PUSH), .RAS_POP(RAS_POP),
    .PC(PC), .PC_PLUS(PC_PLUS), .RAS_TOP(RAS_TOP),
    .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
  endfunction

  // Model of one clock edge, using the inputs as driven before the edge.
  task automatic model_edge();
    logic [31:0] plus, top, cand;
    if (RST) begin
      m_pc  = 32'h0;
      m_mis = 1'b0;
      m_ras.delete();
    end else if (!STALL) begin
      plus = m_pc + 32'd4;
      top  = m_top();
      case (PC_SRC)
        3'd1: cand = JALR_TGT;
        3'd2: cand = BRANCH_TGT;
        3'd3: cand = JAL_TGT;
        3'd4: cand = MTVEC;
        3'd5: cand = MEPC;
        3'd6: cand = (m_ras.size() != 0) ? top : plus;
        default: cand = plus;
      endcase
      m_pc  = cand & 32'hFFFF_FFFC;
      m_mis = (cand[1:0] != 2'b00);
      if (RAS_PUSH && RAS_POP && m_ras.size() != 0) begin
        m_ras[m_ras.size()-1] = plus;
      end else if (RAS_PUSH) begin
        m_ras.push_back(plus);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (RAS_POP && m_ras.size() != 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("pc", PC, m_pc);
      check("pc_plus", PC_PLUS, m_pc + 32'd4);
      check("ras_top", RAS_TOP, m_top());
      check("ras_empty", {31'b0, RAS_EMPTY}, {31'b0, m_ras.size() == 0});
      check("ras_full", {31'b0, RAS_FULL}, {31'b0, m_ras.size() == 4});
      check("misalign", {31'b0, MISALIGN}, {31'b0, m_mis});
    end
  end

  // One clock cycle; unselected target inputs carry distinct junk so a wrong mux leg shows up.
  task automatic cyc(input bit rst, input bit stall, input logic [2:0] src,
                     input logic [31:0] tgt, input bit push, input bit pop);
    RST = rst; STALL = stall; PC_SRC = src; RAS_PUSH = push; RAS_POP = pop;
    JALR_TGT = 32'h0000_1110; BRANCH_TGT = 32'h0000_2220; JAL_TGT = 32'h0000_3330;
    MTVEC = 32'h0000_4440; MEPC = 32'h0000_5550;
    case (src)
      3'd1: JALR_TGT = tgt;
      3'd2: BRANCH_TGT = tgt;
      3'd3: JAL_TGT = tgt;
      3'd4: MTVEC = tgt;
      3'd5: MEPC = tgt;
      default: ;
    endcase
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    #1;
  endtask

  logic [31:0] pc_before;

  initial begin
    @(negedge CLK);
    cyc(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("lit_reset_pc", PC, 32'h0);
    check("lit_reset_empty", {31'b0, RAS_EMPTY}, 32'h1);

    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    check("lit_seq_pc", PC, 32'hC);
    check("lit_seq_plus", PC_PLUS, 32'h10);

    cyc(0, 0, 3, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("lit_wrap_pc", PC, 32'h0);
    repeat (2) cyc(0, 1, 3, 32'h100, 0, 0);
    check("lit_stall_pc", PC, 32'h0);
    cyc(0, 0, 3, 32'h100, 0, 0);
    check("lit_release_pc", PC, 32'h100);

    cyc(0, 0, 2, 32'h202, 0, 0);
    check("lit_branch_pc", PC, 32'h200);
    check("lit_misalign_set", {31'b0, MISALIGN}, 32'h1);
    repeat (2) cyc(0, 1, 4, 32'h80, 0, 0);
    check("lit_misalign_hold", {31'b0, MISALIGN}, 32'h1);
    cyc(0, 0, 4, 32'h80, 0, 0);
    check("lit_mtvec_pc", PC, 32'h80);
    check("lit_misalign_clr", {31'b0, MISALIGN}, 32'h0);
    cyc(0, 0, 7, 0, 0, 0);
    check("lit_src7_pc", PC, 32'h84);
    cyc(0, 0, 1, 32'h301, 0, 0);
    cyc(0, 0, 5, 32'h40, 0, 0);
    check("lit_mepc_pc", PC, 32'h40);

    cyc(0, 0, 3, 32'h400, 1, 0);
    check("lit_call_pc", PC, 32'h400);
    check("lit_call_top", RAS_TOP, 32'h44);
    cyc(0, 0, 6, 0, 0, 1);
    check("lit_ret_pc", PC, 32'h44);
    check("lit_ret_empty", {31'b0, RAS_EMPTY}, 32'h1);

    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 3, 32'h10 * i, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    check("lit_ovf_full", {31'b0, RAS_FULL}, 32'h1);
    check("lit_ovf_top", RAS_TOP, 32'h54);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_pop1_top", RAS_TOP, 32'h44);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_pop2_top", RAS_TOP, 32'h34);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_pop3_top", RAS_TOP, 32'h24);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_pop4_empty", {31'b0, RAS_EMPTY}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_underflow_top", RAS_TOP, 32'h0);
    pc_before = PC;
    cyc(0, 0, 6, 0, 0, 0);
    check("lit_ret_empty_pc", PC, pc_before + 32'd4);

    cyc(0, 0, 2, 32'h502, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 3, 32'h700, 1, 0);
    check("lit_rst_pc", PC, 32'h0);
    check("lit_rst_empty", {31'b0, RAS_EMPTY}, 32'h1);
    check("lit_rst_mis", {31'b0, MISALIGN}, 32'h0);

    cyc(0, 0, 3, 32'h60, 1, 0);
    check("lit_one_top", RAS_TOP, 32'h4);
    cyc(0, 0, 0, 0, 1, 1);
    check("lit_pp_top", RAS_TOP, 32'h64);
    check("lit_pp_notempty", {31'b0, RAS_EMPTY}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1);
    check("lit_pp_count1", {31'b0, RAS_EMPTY}, 32'h1);
    cyc(0, 0, 0, 0, 1, 1);
    check("lit_pp_empty_push", RAS_TOP, 32'h6C);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised program-counter generator that replaces the bare PC+4 adder plus external PC register.
- Holds the architectural PC and computes PC+INC internally.
- Selects the next PC from sequential, branch, jump, trap and return sources, with stall support.
- Contains a small circular return-address stack (RAS) for call/return prediction. Sits at the head of the fetch stage, feeding instruction-memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VEC, 0, PC value loaded on reset (XLEN bits).
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- STALL  in  1  1 = freeze PC and RAS this cycle.
- PC_SRC  in  3  next-PC select: 0 seq, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc, 6 ras; 7 reserved.
- JALR_TGT  in  XLEN  jalr target.
- BRANCH_TGT  in  XLEN  branch target.
- JAL_TGT  in  XLEN  jal target.
- MTVEC  in  XLEN  trap vector.
- MEPC  in  XLEN  trap return address.
- RAS_PUSH  in  1  push current PC_PLUS (call).
- RAS_POP  in  1  pop top entry (return).
- PC  out  XLEN  current PC (registered).
- PC_PLUS  out  XLEN  PC + INC, combinational from PC.
- RAS_TOP  out  XLEN  top-of-stack entry; 0 when empty.
- RAS_EMPTY  out  1  RAS count == 0.
- RAS_FULL  out  1  RAS count == RAS_DEPTH.
- MISALIGN  out  1  registered flag: last loaded target had bits[1:0] ≠ 0.

Behaviour:
- Reset (RST=1 at clock edge) has priority over STALL and all other inputs:
  - PC ← RESET_VEC, MISALIGN ← 0, RAS count ← 0, RAS pointer ← 0.
  - RAS entry contents are don't-care; RAS_TOP reads 0.
- PC_PLUS = PC + INC, truncated to XLEN bits (wraps modulo 2^XLEN; no carry out).
- Next-PC candidate selection:
  - Source 0 → PC_PLUS.
  - Sources 1–5 → the matching input.
  - Source 6 → RAS_TOP if not empty, otherwise PC_PLUS.
  - Source 7 → PC_PLUS.
- Alignment:
  - If the candidate's bits[1:0] ≠ 0, PC loads the candidate with bits[1:0] forced to 0 and MISALIGN ← 1.
  - Otherwise MISALIGN ← 0.
  - MISALIGN updates only on non-stalled edges.
- Latency:
  - New PC is visible 1 cycle after the edge that samples PC_SRC.
  - PC_PLUS and RAS_TOP are combinational from state (0 extra cycles).
- STALL=1 (RST=0): PC, MISALIGN, RAS count, pointer and entries all hold. PUSH and POP are ignored.
- RAS operations on a non-stalled edge:
  - Push only: write the pre-edge PC_PLUS at ptr+1 (mod RAS_DEPTH); ptr ← ptr+1; count ← min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry (circular); count stays RAS_DEPTH; RAS_FULL stays 1.
  - Pop only, count > 0: ptr ← ptr−1, count ← count−1.
  - Pop when empty: no change, no error.
  - Push and pop together: replace the top entry with the pre-edge PC_PLUS; ptr and count unchanged. If empty, treat as push only.
  - PC_SRC=6 together with RAS_POP uses the pre-pop RAS_TOP as target (normal return).
- All outputs are driven from registered state or combinational logic from it; there are no combinational paths from inputs to PC or MISALIGN.

Test Plan:
- Reset and sequential: RST 1 cycle with RESET_VEC=0 → PC=0. Then 3 cycles PC_SRC=0 → PC=4, 8, 0xC; PC_PLUS=0x10.
- Wrap and stall: force PC=0xFFFFFFFC via JAL_TGT, then PC_SRC=0 → PC=0x0. STALL=1 for 2 cycles with PC_SRC=3, JAL_TGT=0x100 → PC holds 0x0. Release STALL → PC=0x100.
- Source priority and misalign: PC_SRC=2, BRANCH_TGT=0x202 → PC=0x200, MISALIGN=1. Next PC_SRC=4, MTVEC=0x80 → PC=0x80, MISALIGN=0. PC_SRC=7 → PC=0x84.
- Call/return: at PC=0x40 assert RAS_PUSH with PC_SRC=3, JAL_TGT=0x400 → PC=0x400, RAS_TOP=0x44, RAS_EMPTY=0. Then PC_SRC=6 with RAS_POP → PC=0x44, RAS_EMPTY=1.
- Overflow/underflow (RAS_DEPTH=4): push at PCs 0x10, 0x20, 0x30, 0x40, 0x50 → RAS_FULL=1, RAS_TOP=0x54. Pop ×4 → tops 0x44, 0x34, 0x24 then empty; 0x14 is lost. Extra pop → no change. PC_SRC=6 while empty → PC=PC+4.
- Reset mid-operation: with 2 RAS entries, STALL=1 and RST=1 on the same edge → PC=RESET_VEC, RAS_EMPTY=1, MISALIGN=0. Simultaneous push+pop on a 1-entry stack at PC=0x60 → count stays 1, RAS_TOP=0x64.
